// File: rtl/instr_encoder_pkg.sv
// ----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared types and constants for the LEGv8 instruction encoder: instruction
// format enum, immediate field widths, a few left-justified opcodes, the
// out-stage state type and an immediate fit-check helper.
// Optional feature macro used by the importing files: ENC_RANGE_CHECK_EN.
// ----------------------------------------------------------------------------
package instr_encoder_pkg;

   typedef enum logic [1:0] {
      FMT_D  = 2'd0,
      FMT_CB = 2'd1,
      FMT_R  = 2'd2,
      FMT_B  = 2'd3
   } fmt_t;

   typedef enum logic {
      OST_EMPTY = 1'b0,
      OST_HOLD  = 1'b1
   } ost_t;

   localparam int IMM_D_W  = 9;
   localparam int IMM_CB_W = 19;
   localparam int IMM_B_W  = 26;
   localparam int SHAMT_W  = 6;

   // Opcodes are left-justified in 11 bits; CB uses [10:3], B uses [10:5].
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100000;
   localparam logic [10:0] OP_B    = 11'b00010100000;
   localparam logic [10:0] OP_ADD  = 11'b10001011000;

   // True when v sign-extends losslessly from a w-bit field: bits [63:w-1]
   // must be all zeros or all ones.
   function automatic logic fits_signed(input logic [63:0] v, input int w);
      logic [63:0] m;
      m = ~64'd0 << (w - 1);
      return ((v & m) == 64'd0) || ((v & m) == m);
   endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// ----------------------------------------------------------------------------
// instr_encoder_pack
// Combinational field packer: builds a 32-bit LEGv8 word from decoded fields
// and flags an immediate that does not fit its field.
// Macro: ENC_RANGE_CHECK_EN enables the immediate range check; without it
// range_err_o is tied low and immediates are silently truncated.
// Ports:
//   fmt_i       instruction format
//   opcode_i    left-justified 11-bit opcode
//   imm_i       64-bit signed immediate (R: [5:0] is shamt)
//   rn_i/rt_i/rm_i  register fields
//   instr_o     packed instruction word
//   range_err_o immediate out of range for this format
// ----------------------------------------------------------------------------
module instr_encoder_pack
   import instr_encoder_pkg::*;
(
   input  fmt_t        fmt_i,
   input  logic [10:0] opcode_i,
   input  logic [63:0] imm_i,
   input  logic [4:0]  rn_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rm_i,
   output logic [31:0] instr_o,
   output logic        range_err_o
);

   always_comb begin
      instr_o = 32'd0;
      case (fmt_i)
         FMT_D:  instr_o = {opcode_i, imm_i[IMM_D_W-1:0], 2'b00, rn_i, rt_i};
         FMT_CB: instr_o = {opcode_i[10:3], imm_i[IMM_CB_W-1:0], rt_i};
         FMT_R:  instr_o = {opcode_i, rm_i, imm_i[SHAMT_W-1:0], rn_i, rt_i};
         FMT_B:  instr_o = {opcode_i[10:5], imm_i[IMM_B_W-1:0]};
         default: instr_o = 32'd0;
      endcase
   end

`ifdef ENC_RANGE_CHECK_EN
   always_comb begin
      range_err_o = 1'b0;
      case (fmt_i)
         FMT_D:  range_err_o = !fits_signed(imm_i, IMM_D_W);
         FMT_CB: range_err_o = !fits_signed(imm_i, IMM_CB_W);
         // shamt is unsigned: anything outside 0..63 is an error
         FMT_R:  range_err_o = (imm_i[63:SHAMT_W] != '0);
         FMT_B:  range_err_o = !fits_signed(imm_i, IMM_B_W);
         default: range_err_o = 1'b0;
      endcase
   end
`else
   // Upper immediate bits only matter to the range check.
   logic unused_imm_hi;
   assign unused_imm_hi = ^imm_i[63:IMM_B_W];
   assign range_err_o   = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
// Packs decoded LEGv8 fields into 32-bit instruction words and pairs each with
// a sequential instruction-memory address, for the imem preload port.
// Single registered stage with valid/ready on both sides; the address counter
// stops at DEPTH and then refuses further input.
// Macro: ENC_RANGE_CHECK_EN enables the sticky range_err flag.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   input bundle handshake
//   fmt, opcode, imm, rn, rt, rm   decoded fields
//   out_valid/out_ready output word handshake
//   out_instr, out_addr encoded word and its memory address
//   range_err           sticky: some accepted immediate did not fit
//   full                DEPTH words have been accepted
// ----------------------------------------------------------------------------
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    fmt,
   input  logic [10:0]   opcode,
   input  logic [63:0]   imm,
   input  logic [4:0]    rn,
   input  logic [4:0]    rt,
   input  logic [4:0]    rm,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_instr,
   output logic [AW-1:0] out_addr,
   output logic          range_err,
   output logic          full
);

   ost_t          state_q, state_d;
   logic [AW:0]   cnt_q;      // one extra bit so the count can reach DEPTH
   logic [31:0]   instr_q;
   logic [AW-1:0] addr_q;
   logic          rerr_q;
   logic [31:0]   pack_instr;
   logic          pack_err;
   logic          acc;

   instr_encoder_pack u_pack (
      .fmt_i       (fmt_t'(fmt)),
      .opcode_i    (opcode),
      .imm_i       (imm),
      .rn_i        (rn),
      .rt_i        (rt),
      .rm_i        (rm),
      .instr_o     (pack_instr),
      .range_err_o (pack_err)
   );

   assign full      = (cnt_q == (AW+1)'(DEPTH));
   assign out_valid = (state_q == OST_HOLD);
   assign in_ready  = !full && (!out_valid || out_ready);
   assign acc       = in_valid && in_ready;
   assign out_instr = instr_q;
   assign out_addr  = addr_q;
   assign range_err = rerr_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         OST_EMPTY: if (acc) state_d = OST_HOLD;
         OST_HOLD:  if (acc) state_d = OST_HOLD;
                    else if (out_ready) state_d = OST_EMPTY;
         default:   state_d = OST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= OST_EMPTY;
         cnt_q   <= '0;
         instr_q <= '0;
         addr_q  <= '0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (acc) begin
            instr_q <= pack_instr;
            addr_q  <= cnt_q[AW-1:0];
            cnt_q   <= cnt_q + 1'b1;
            rerr_q  <= rerr_q | pack_err;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
// Directed-vector bench for instr_encoder. Expected words are hand-packed
// constants; range_err expectations follow ENC_RANGE_CHECK_EN.
// ----------------------------------------------------------------------------
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   localparam int DEPTH = 64;
   localparam int AW    = 6;
`ifdef ENC_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    fmt;
   logic [10:0]   opcode;
   logic [63:0]   imm;
   logic [4:0]    rn, rt, rm;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instr;
   logic [AW-1:0] out_addr;
   logic          range_err;
   logic          full;

   int n_vec = 0;
   int n_bad = 0;

   instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .imm(imm), .rn(rn), .rt(rt), .rm(rm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_addr(out_addr), .range_err(range_err), .full(full)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus helpers: drive after the edge, outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic [1:0] f, input logic [10:0] op, input logic [63:0] im,
                        input logic [4:0] n, input logic [4:0] t, input logic [4:0] m);
      in_valid = 1'b1; fmt = f; opcode = op; imm = im; rn = n; rt = t; rm = m;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      // a valid bundle presented while reset is high must be dropped
      reset = 1'b1; out_ready = 1'b0;
      drive(2'd0, OP_LDUR, 64'd16, 5'd5, 5'd6, 5'd0);
      tick();
      reset = 1'b0; in_valid = 1'b0;
      #1;
      n_vec += 5;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      if (out_instr !== 32'd0) begin n_bad++; $display("FAIL rst_out_instr got %h want 0", out_instr); end
      if (out_addr !== '0) begin n_bad++; $display("FAIL rst_out_addr got %0d want 0", out_addr); end
      if (range_err !== 1'b0) begin n_bad++; $display("FAIL rst_range_err got %b want 0", range_err); end
      if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full got %b want 0", full); end
   endtask

   task automatic test_d();
      out_ready = 1'b1;
      drive(2'd0, OP_LDUR, 64'd16, 5'd5, 5'd6, 5'd0);
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL d_in_ready got %b want 1", in_ready); end
      tick();
      in_valid = 1'b0;
      n_vec += 4;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL d_valid got %b want 1", out_valid); end
      if (out_instr !== 32'hF84100A6) begin n_bad++; $display("FAIL d_instr got %h want F84100A6", out_instr); end
      if (out_addr !== 6'd0) begin n_bad++; $display("FAIL d_addr got %0d want 0", out_addr); end
      if (range_err !== 1'b0) begin n_bad++; $display("FAIL d_rerr got %b want 0", range_err); end
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL d_drain got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_i [5];
      do_reset();
      exp_i[0] = 32'hB4FFFFA3; exp_i[1] = 32'hF807C022; exp_i[2] = 32'h8B021423;
      exp_i[3] = 32'h14000004; exp_i[4] = 32'h17FFFFFF;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: drive(2'd1, OP_CBZ,  64'hFFFF_FFFF_FFFF_FFFD, 5'd7, 5'd3, 5'd0);
            1: drive(2'd0, OP_STUR, 64'd124, 5'd1, 5'd2, 5'd0);
            2: drive(2'd2, OP_ADD,  64'd5,   5'd1, 5'd3, 5'd2);
            3: drive(2'd3, OP_B,    64'd4,   5'd0, 5'd0, 5'd0);
            default: drive(2'd3, OP_B, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0, 5'd0);
         endcase
         #1;
         n_vec++;
         if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
         tick();
         n_vec += 3;
         if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d] got %b want 1", i, out_valid); end
         if (out_instr !== exp_i[i]) begin n_bad++; $display("FAIL b2b_instr[%0d] got %h want %h", i, out_instr, exp_i[i]); end
         if (out_addr !== AW'(i)) begin n_bad++; $display("FAIL b2b_addr[%0d] got %0d want %0d", i, out_addr, i); end
      end
      in_valid = 1'b0;
      n_vec++;
      if (range_err !== 1'b0) begin n_bad++; $display("FAIL b2b_rerr got %b want 0", range_err); end
      tick();
   endtask

   task automatic test_stall();
      do_reset();
      drive(2'd0, OP_LDUR, 64'd16, 5'd5, 5'd6, 5'd0);
      tick();
      out_ready = 1'b0;
      drive(2'd3, OP_B, 64'd4, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_vec++;
         if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready[%0d] got %b want 0", i, in_ready); end
         tick();
         n_vec += 3;
         if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d] got %b want 1", i, out_valid); end
         if (out_instr !== 32'hF84100A6) begin n_bad++; $display("FAIL stall_instr[%0d] got %h want F84100A6", i, out_instr); end
         if (out_addr !== 6'd0) begin n_bad++; $display("FAIL stall_addr[%0d] got %0d want 0", i, out_addr); end
      end
      out_ready = 1'b1; in_valid = 1'b0;
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_dup got %b want 0", out_valid); end
      // the bundle offered during the stall was never taken, so this is addr 1
      drive(2'd3, OP_B, 64'd4, 5'd0, 5'd0, 5'd0);
      tick();
      in_valid = 1'b0;
      n_vec += 2;
      if (out_addr !== 6'd1) begin n_bad++; $display("FAIL stall_next_addr got %0d want 1", out_addr); end
      if (out_instr !== 32'h14000004) begin n_bad++; $display("FAIL stall_next_instr got %h want 14000004", out_instr); end
      tick();
   endtask

   typedef struct {
      logic [1:0]  f;
      logic [10:0] op;
      logic [63:0] im;
      logic [31:0] ins;
      bit          bad;
   } rvec_t;

   task automatic test_range();
      rvec_t v [10];
      v[0] = '{2'd0, OP_LDUR, 64'd300,                   32'hF852C000, 1'b1};
      v[1] = '{2'd0, OP_LDUR, 64'hFFFF_FFFF_FFFF_FF00,   32'hF8500000, 1'b0};
      v[2] = '{2'd0, OP_LDUR, 64'd256,                   32'hF8500000, 1'b1};
      v[3] = '{2'd1, OP_CBZ,  64'hFFFF_FFFF_FFFC_0000,   32'hB4800000, 1'b0};
      v[4] = '{2'd1, OP_CBZ,  64'd262144,                32'hB4800000, 1'b1};
      v[5] = '{2'd2, OP_ADD,  64'd63,                    32'h8B02FC23, 1'b0};
      v[6] = '{2'd2, OP_ADD,  64'd64,                    32'h8B020023, 1'b1};
      v[7] = '{2'd2, OP_ADD,  64'hFFFF_FFFF_FFFF_FFFF,   32'h8B02FC23, 1'b1};
      v[8] = '{2'd3, OP_B,    64'hFFFF_FFFF_FE00_0000,   32'h16000000, 1'b0};
      v[9] = '{2'd3, OP_B,    64'd33554432,              32'h16000000, 1'b1};
      for (int i = 0; i < 10; i++) begin
         do_reset();
         // R vectors use rn=1 rt=3 rm=2; the others use zero registers
         if (v[i].f == 2'd2) drive(v[i].f, v[i].op, v[i].im, 5'd1, 5'd3, 5'd2);
         else drive(v[i].f, v[i].op, v[i].im, 5'd0, 5'd0, 5'd0);
         tick();
         in_valid = 1'b0;
         n_vec += 2;
         if (out_instr !== v[i].ins) begin n_bad++; $display("FAIL range_instr[%0d] got %h want %h", i, out_instr, v[i].ins); end
         if (range_err !== (v[i].bad & RC)) begin n_bad++; $display("FAIL range_err[%0d] got %b want %b", i, range_err, v[i].bad & RC); end
      end
      // stickiness: error from an earlier word survives later good words
      do_reset();
      drive(2'd0, OP_LDUR, 64'd300, 5'd0, 5'd0, 5'd0);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(2'd0, OP_LDUR, 64'd16, 5'd5, 5'd6, 5'd0);
         tick();
         n_vec += 2;
         if (out_instr !== 32'hF84100A6) begin n_bad++; $display("FAIL sticky_instr[%0d] got %h want F84100A6", i, out_instr); end
         if (range_err !== RC) begin n_bad++; $display("FAIL sticky_rerr[%0d] got %b want %b", i, range_err, RC); end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_full();
      int  acc;
      logic took;
      acc = 0;
      do_reset();
      drive(2'd0, OP_LDUR, 64'd16, 5'd5, 5'd6, 5'd0);
      for (int i = 0; i < DEPTH + 2; i++) begin
         #1;
         took = in_ready;
         tick();
         if (took) begin
            n_vec += 2;
            if (out_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid[%0d] got %b want 1", i, out_valid); end
            if (out_addr !== AW'(acc)) begin n_bad++; $display("FAIL full_addr[%0d] got %0d want %0d", i, out_addr, acc); end
            acc++;
         end else begin
            n_vec++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL full_extra[%0d] got %b want 0", i, out_valid); end
         end
         n_vec++;
         if (full !== (acc == DEPTH)) begin n_bad++; $display("FAIL full_flag[%0d] got %b want %b", i, full, acc == DEPTH); end
      end
      n_vec += 2;
      if (acc != DEPTH) begin n_bad++; $display("FAIL full_count got %0d want %0d", acc, DEPTH); end
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got %b want 0", in_ready); end
      do_reset();
      n_vec += 2;
      if (full !== 1'b0) begin n_bad++; $display("FAIL full_clear got %b want 0", full); end
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_clear_ready got %b want 1", in_ready); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      drive(2'd0, OP_LDUR, 64'd300, 5'd0, 5'd0, 5'd0);
      tick();
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_vec += 5;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got %b want 0", out_valid); end
      if (out_addr !== 6'd0) begin n_bad++; $display("FAIL mid_addr got %0d want 0", out_addr); end
      if (out_instr !== 32'd0) begin n_bad++; $display("FAIL mid_instr got %h want 0", out_instr); end
      if (full !== 1'b0) begin n_bad++; $display("FAIL mid_full got %b want 0", full); end
      if (range_err !== 1'b0) begin n_bad++; $display("FAIL mid_rerr got %b want 0", range_err); end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      fmt = '0; opcode = '0; imm = '0; rn = '0; rt = '0; rm = '0;
      tick();
      test_reset();
      test_d();
      test_back_to_back();
      test_stall();
      test_range();
      test_full();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
